// File: rtl/iu_pkg.sv
// Shared integer-unit definitions: Bicc condition encodings, icc bit positions
// and the branch sequencer state type.
package iu_pkg;

  localparam logic [3:0] COND_BN   = 4'h0;
  localparam logic [3:0] COND_BE   = 4'h1;
  localparam logic [3:0] COND_BLE  = 4'h2;
  localparam logic [3:0] COND_BL   = 4'h3;
  localparam logic [3:0] COND_BLEU = 4'h4;
  localparam logic [3:0] COND_BCS  = 4'h5;
  localparam logic [3:0] COND_BNEG = 4'h6;
  localparam logic [3:0] COND_BVS  = 4'h7;
  localparam logic [3:0] COND_BA   = 4'h8;
  localparam logic [3:0] COND_BNE  = 4'h9;
  localparam logic [3:0] COND_BG   = 4'hA;
  localparam logic [3:0] COND_BGE  = 4'hB;
  localparam logic [3:0] COND_BGU  = 4'hC;
  localparam logic [3:0] COND_BCC  = 4'hD;
  localparam logic [3:0] COND_BPOS = 4'hE;
  localparam logic [3:0] COND_BVC  = 4'hF;

  localparam int ICC_N = 3;
  localparam int ICC_Z = 2;
  localparam int ICC_V = 1;
  localparam int ICC_C = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLOT  = 2'd1,
    REDIR = 2'd2
  } br_state_t;

endpackage

// File: rtl/iu_cond_eval.sv
// Combinational evaluation of a SPARC Bicc/Ticc condition against {N,Z,V,C}.
module iu_cond_eval
  import iu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] icc,
  output logic       taken
);

  logic n, z, v, c;
  logic base;

  assign n = icc[ICC_N];
  assign z = icc[ICC_Z];
  assign v = icc[ICC_V];
  assign c = icc[ICC_C];

  // The upper half of the encoding is the complement of the lower half,
  // which also turns "never" into "always".
  always_comb begin
    base = 1'b0;
    case (cond[2:0])
      3'd0: base = 1'b0;
      3'd1: base = z;
      3'd2: base = z | (n ^ v);
      3'd3: base = n ^ v;
      3'd4: base = c | z;
      3'd5: base = c;
      3'd6: base = n;
      3'd7: base = v;
      default: base = 1'b0;
    endcase
  end

  assign taken = base ^ cond[3];

endmodule

// File: rtl/iu_branch_unit.sv
// Holds the icc register, resolves Bicc conditions and sequences the delay
// slot (with annul) before issuing a one-cycle fetch redirect.
module iu_branch_unit
  import iu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DISPW = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             icc_we,
  input  logic [3:0]       icc_in,
  input  logic             stall,
  input  logic             issue_valid,
  input  logic             br_valid,
  input  logic [3:0]       br_cond,
  input  logic             br_annul,
  input  logic [DISPW-1:0] br_disp,
  input  logic [XLEN-1:0]  br_pc,
  output logic [3:0]       icc,
  output logic             busy,
  output logic             annul_slot,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             dcti_err
);

  br_state_t       state;
  logic [3:0]      eff_icc;
  logic            cond_taken;
  logic [XLEN-1:0] disp_ext;
  logic [XLEN-1:0] br_target;
  logic            issue_go;
  logic            branch_go;
  logic            taken_q;
  logic            annul_q;
  logic [XLEN-1:0] target_q;

  // A cc-setting op in the same cycle as the Bicc must be seen by it.
  assign eff_icc = icc_we ? icc_in : icc;

  iu_cond_eval u_cond_eval (
    .cond  (br_cond),
    .icc   (eff_icc),
    .taken (cond_taken)
  );

  assign disp_ext  = {{(XLEN-DISPW-2){br_disp[DISPW-1]}}, br_disp, 2'b00};
  assign br_target = br_pc + disp_ext;

  assign issue_go   = issue_valid & ~stall;
  assign branch_go  = issue_go & br_valid;
  assign annul_slot = (state == SLOT) & annul_q & issue_go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icc <= 4'b0000;
    end else if (icc_we) begin
      icc <= icc_in;
    end
  end

  // A Bicc in the slot (DCTI couple) is flagged but never replaces the
  // outcome already latched for the first branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      taken_q     <= 1'b0;
      annul_q     <= 1'b0;
      target_q    <= '0;
      busy        <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      dcti_err    <= 1'b0;
    end else begin
      redirect <= 1'b0;
      dcti_err <= 1'b0;
      case (state)
        IDLE: begin
          if (branch_go) begin
            taken_q  <= cond_taken;
            target_q <= br_target;
            annul_q  <= br_annul & ((br_cond == COND_BA) | ~cond_taken);
            state    <= SLOT;
            busy     <= 1'b1;
          end
        end
        SLOT: begin
          if (issue_go) begin
            dcti_err <= br_valid;
            if (taken_q) begin
              state       <= REDIR;
              redirect    <= 1'b1;
              redirect_pc <= target_q;
              busy        <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        REDIR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iu_branch_unit.sv
// Self-checking bench for iu_branch_unit: directed delay-slot sequences plus a
// sweep of all 16 conditions against every icc value.
module tb_iu_branch_unit;

  logic        clk;
  logic        rst_n;
  logic        icc_we;
  logic [3:0]  icc_in;
  logic        stall;
  logic        issue_valid;
  logic        br_valid;
  logic [3:0]  br_cond;
  logic        br_annul;
  logic [21:0] br_disp;
  logic [31:0] br_pc;
  logic [3:0]  icc;
  logic        busy;
  logic        annul_slot;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dcti_err;

  int checks;
  int failures;

  typedef struct {
    logic        we;
    logic [3:0]  icc_in;
    logic        stall;
    logic        iv;
    logic        bv;
    logic [3:0]  cond;
    logic        a;
    logic [21:0] disp;
    logic [31:0] pc;
    logic        x_annul;
    logic        x_busy;
    logic        x_redir;
    logic [31:0] x_rpc;
    logic        x_dcti;
    logic [3:0]  x_icc;
  } vec_t;

  typedef struct {
    logic        busy;
    logic        redir;
    logic [31:0] rpc;
    logic        dcti;
    logic [3:0]  icc;
  } exp_t;

  typedef struct {
    logic [3:0] cond;
    logic [3:0] flags;
    logic       taken;
  } cond_vec_t;

  vec_t      vecs[$];
  exp_t      exp_q[$];
  cond_vec_t cv[256];

  iu_branch_unit #(.XLEN(32), .DISPW(22)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .icc_we      (icc_we),
    .icc_in      (icc_in),
    .stall       (stall),
    .issue_valid (issue_valid),
    .br_valid    (br_valid),
    .br_cond     (br_cond),
    .br_annul    (br_annul),
    .br_disp     (br_disp),
    .br_pc       (br_pc),
    .icc         (icc),
    .busy        (busy),
    .annul_slot  (annul_slot),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dcti_err    (dcti_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic ref_taken(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, v, c;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (cond)
      4'h0: return 1'b0;
      4'h1: return z;
      4'h2: return z | (n ^ v);
      4'h3: return n ^ v;
      4'h4: return c | z;
      4'h5: return c;
      4'h6: return n;
      4'h7: return v;
      4'h8: return 1'b1;
      4'h9: return !z;
      4'hA: return !(z | (n ^ v));
      4'hB: return !(n ^ v);
      4'hC: return !(c | z);
      4'hD: return !c;
      4'hE: return !n;
      default: return !v;
    endcase
  endfunction

  function automatic vec_t mk(
    input logic we, input logic [3:0] iin, input logic st, input logic iv,
    input logic bv, input logic [3:0] cond, input logic a, input logic [21:0] disp,
    input logic [31:0] pc, input logic x_annul, input logic x_busy,
    input logic x_redir, input logic [31:0] x_rpc, input logic x_dcti,
    input logic [3:0] x_icc);
    vec_t v;
    v.we = we; v.icc_in = iin; v.stall = st; v.iv = iv; v.bv = bv;
    v.cond = cond; v.a = a; v.disp = disp; v.pc = pc;
    v.x_annul = x_annul; v.x_busy = x_busy; v.x_redir = x_redir;
    v.x_rpc = x_rpc; v.x_dcti = x_dcti; v.x_icc = x_icc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, want);
    end
  endtask

  // Drive one cycle of inputs, check the combinational annul before the edge
  // and the registered outputs just after it.
  task automatic applyStimulus(input string name, input vec_t v);
    exp_t e;
    icc_we = v.we; icc_in = v.icc_in; stall = v.stall;
    issue_valid = v.iv; br_valid = v.bv; br_cond = v.cond;
    br_annul = v.a; br_disp = v.disp; br_pc = v.pc;
    exp_q.push_back('{busy: v.x_busy, redir: v.x_redir, rpc: v.x_rpc,
                      dcti: v.x_dcti, icc: v.x_icc});
    @(negedge clk);
    checkOutput({name, ".annul_slot"}, {31'd0, annul_slot}, {31'd0, v.x_annul});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checkOutput({name, ".busy"}, {31'd0, busy}, {31'd0, e.busy});
    checkOutput({name, ".redirect"}, {31'd0, redirect}, {31'd0, e.redir});
    checkOutput({name, ".redirect_pc"}, redirect_pc, e.rpc);
    checkOutput({name, ".dcti_err"}, {31'd0, dcti_err}, {31'd0, e.dcti});
    checkOutput({name, ".icc"}, {28'd0, icc}, {28'd0, e.icc});
  endtask

  task automatic run_vecs(input string name);
    for (int i = 0; i < vecs.size(); i++)
      applyStimulus($sformatf("%s[%0d]", name, i), vecs[i]);
    vecs.delete();
  endtask

  initial begin
    logic [31:0] rpc_track;
    logic [31:0] pc;
    logic        t;
    string       nm;

    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    icc_we = 0; icc_in = 0; stall = 0; issue_valid = 0; br_valid = 0;
    br_cond = 0; br_annul = 0; br_disp = 0; br_pc = 0;

    for (int i = 0; i < 256; i++) begin
      cv[i].cond  = i[7:4];
      cv[i].flags = i[3:0];
      cv[i].taken = ref_taken(i[7:4], i[3:0]);
    end

    #2;
    checkOutput("reset.icc", {28'd0, icc}, 32'd0);
    checkOutput("reset.busy", {31'd0, busy}, 32'd0);
    checkOutput("reset.annul_slot", {31'd0, annul_slot}, 32'd0);
    checkOutput("reset.redirect", {31'd0, redirect}, 32'd0);
    checkOutput("reset.redirect_pc", redirect_pc, 32'd0);
    checkOutput("reset.dcti_err", {31'd0, dcti_err}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Same-cycle icc bypass into BE, then a wrong-path BA during REDIR.
    vecs.push_back(mk(1, 4'b0100, 0, 1, 1, 4'h1, 0, 22'h000010, 32'h1000, 0, 1, 0, 32'h0,    0, 4'b0100));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 0, 4'h0, 0, 22'h0,      32'h0,    0, 1, 1, 32'h1040, 0, 4'b0100));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 1, 4'h8, 0, 22'h000100, 32'h5000, 0, 0, 0, 32'h1040, 0, 4'b0100));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'h0, 0, 22'h0,      32'h0,    0, 0, 0, 32'h1040, 0, 4'b0100));
    run_vecs("bypass");

    vecs.push_back(mk(1, 4'b0000, 0, 1, 1, 4'h1, 1, 22'h000004, 32'h2000, 0, 1, 0, 32'h1040, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 0, 4'h0, 0, 22'h0,      32'h0,    1, 0, 0, 32'h1040, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 0, 4'h0, 0, 22'h0,      32'h0,    0, 0, 0, 32'h1040, 0, 4'b0000));
    run_vecs("annul_untaken");

    vecs.push_back(mk(0, 4'b0000, 0, 1, 1, 4'h8, 1, 22'h3FFFFE, 32'h8, 0, 1, 0, 32'h1040,     0, 4'b0000));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 0, 4'h0, 0, 22'h0,      32'h0, 1, 1, 1, 32'h0,        0, 4'b0000));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'h0, 0, 22'h0,      32'h0, 0, 0, 0, 32'h0,        0, 4'b0000));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 1, 4'h8, 1, 22'h3FFFFE, 32'h4, 0, 1, 0, 32'h0,        0, 4'b0000));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 0, 4'h0, 0, 22'h0,      32'h0, 1, 1, 1, 32'hFFFFFFFC, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'h0, 0, 22'h0,      32'h0, 0, 0, 0, 32'hFFFFFFFC, 0, 4'b0000));
    run_vecs("ba_negative");

    // Slot held by stall (icc still writable), REDIR exits under stall,
    // and a stalled Bicc in IDLE is ignored.
    vecs.push_back(mk(0, 4'b0000, 0, 1, 1, 4'h8, 1, 22'h000001, 32'h3000, 0, 1, 0, 32'hFFFFFFFC, 0, 4'b0000));
    vecs.push_back(mk(1, 4'b1010, 1, 1, 0, 4'h0, 0, 22'h0,      32'h0,    0, 1, 0, 32'hFFFFFFFC, 0, 4'b1010));
    vecs.push_back(mk(0, 4'b0000, 1, 1, 0, 4'h0, 0, 22'h0,      32'h0,    0, 1, 0, 32'hFFFFFFFC, 0, 4'b1010));
    vecs.push_back(mk(0, 4'b0000, 1, 1, 0, 4'h0, 0, 22'h0,      32'h0,    0, 1, 0, 32'hFFFFFFFC, 0, 4'b1010));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 0, 4'h0, 0, 22'h0,      32'h0,    1, 1, 1, 32'h3004,     0, 4'b1010));
    vecs.push_back(mk(0, 4'b0000, 1, 1, 0, 4'h0, 0, 22'h0,      32'h0,    0, 0, 0, 32'h3004,     0, 4'b1010));
    vecs.push_back(mk(0, 4'b0000, 1, 1, 1, 4'h8, 0, 22'h000040, 32'h9000, 0, 0, 0, 32'h3004,     0, 4'b1010));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'h0, 0, 22'h0,      32'h0,    0, 0, 0, 32'h3004,     0, 4'b1010));
    run_vecs("stall");

    vecs.push_back(mk(0, 4'b0000, 0, 1, 1, 4'h8, 0, 22'h000100, 32'h6000, 0, 1, 0, 32'h3004, 0, 4'b1010));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 1, 4'h0, 1, 22'h000008, 32'h7000, 0, 1, 1, 32'h6400, 1, 4'b1010));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'h0, 0, 22'h0,      32'h0,    0, 0, 0, 32'h6400, 0, 4'b1010));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'h0, 0, 22'h0,      32'h0,    0, 0, 0, 32'h6400, 0, 4'b1010));
    run_vecs("dcti");

    // Every condition against every icc value, with a=1 so annul exposes
    // the not-taken case and redirect exposes the taken case.
    rpc_track = 32'h6400;
    for (int i = 0; i < 256; i++) begin
      pc = 32'h100 + 32'(i) * 32'd16;
      t  = cv[i].taken;
      nm = $sformatf("cond%0h_icc%0h", cv[i].cond, cv[i].flags);
      applyStimulus({nm, ".issue"},
        mk(1, cv[i].flags, 0, 1, 1, cv[i].cond, 1, 22'h000005, pc,
           0, 1, 0, rpc_track, 0, cv[i].flags));
      if (t) rpc_track = pc + 32'd20;
      applyStimulus({nm, ".slot"},
        mk(0, 4'b0000, 0, 1, 0, 4'h0, 0, 22'h0, 32'h0,
           (cv[i].cond == 4'h8) | !t, t, t, rpc_track, 0, cv[i].flags));
      applyStimulus({nm, ".idle"},
        mk(0, 4'b0000, 0, 0, 0, 4'h0, 0, 22'h0, 32'h0,
           0, 0, 0, rpc_track, 0, cv[i].flags));
    end

    // Reset asserted mid-SLOT while the slot is issuing a taken branch.
    applyStimulus("midreset.issue",
      mk(0, 4'b0000, 0, 1, 1, 4'h8, 0, 22'h000001, 32'h8000,
         0, 1, 0, rpc_track, 0, 4'hF));
    issue_valid = 1'b1; br_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset.icc", {28'd0, icc}, 32'd0);
    checkOutput("midreset.busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset.redirect", {31'd0, redirect}, 32'd0);
    checkOutput("midreset.annul_slot", {31'd0, annul_slot}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vecs.push_back(mk(0, 4'b0000, 0, 1, 0, 4'h0, 0, 22'h0, 32'h0, 0, 0, 0, 32'h0, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'h0, 0, 22'h0, 32'h0, 0, 0, 0, 32'h0, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'h0, 0, 22'h0, 32'h0, 0, 0, 0, 32'h0, 0, 4'b0000));
    run_vecs("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iu_branch_unit.md
Name: iu_branch_unit

Overview:
- Consumer end of the integer condition codes produced by the IU adder's cc-setting ops (ADDcc, ADDXcc, SUBcc, SUBXcc).
- Holds the architectural icc register {N,Z,V,C} and evaluates the 16 SPARC Bicc conditions.
- Sequences the delayed-branch slot, including the annul bit, and issues a one-cycle fetch redirect for taken branches.
- Sits between the IU execute stage, which supplies icc writes and decoded Bicc, and the fetch unit, which consumes the redirect.

Parameters:
- XLEN, 32, PC/target width.
- DISPW, 22, Bicc displacement width (disp22).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- icc_we  in  1  write enable for icc from an adder cc op.
- icc_in  in  4  new flags {N,Z,V,C}.
- stall  in  1  freeze sequencing; all issue inputs ignored while high.
- issue_valid  in  1  an instruction issues this cycle (any type, including Bicc).
- br_valid  in  1  the issuing instruction is a Bicc; qualified by issue_valid.
- br_cond  in  4  Bicc cond field.
- br_annul  in  1  Bicc a bit.
- br_disp  in  DISPW  signed word displacement.
- br_pc  in  XLEN  PC of the Bicc.
- icc  out  4  current icc register {N,Z,V,C}.
- busy  out  1  high in SLOT or REDIR.
- annul_slot  out  1  kill the instruction issuing this cycle (delay slot).
- redirect  out  1  one-cycle pulse: fetch from redirect_pc.
- redirect_pc  out  XLEN  branch target.
- dcti_err  out  1  one-cycle pulse: Bicc issued in a delay slot (DCTI couple).

Behaviour:
- Reset (async, rst_n=0): icc=0; state IDLE; busy, annul_slot, redirect, dcti_err=0; redirect_pc=0.
- icc register:
  - On icc_we, icc<=icc_in at the clock edge.
  - icc_we is honoured regardless of stall or state.
- Condition evaluation uses eff_icc = icc_we ? icc_in : icc, a bypass of the same-cycle write.
- Condition codes:
  - 0000 never; 0001 Z; 0010 Z|(N^V); 0011 N^V.
  - 0100 C|Z; 0101 C; 0110 N; 0111 V.
  - 1000 always; 1001–1111 are the complements of 0001–0111 respectively.
- Target: br_pc + sext(br_disp)<<2, modulo 2^XLEN; wraps silently.
- State IDLE:
  - On issue_valid&br_valid&!stall: latch taken, target, and annul_now.
  - annul_now = br_annul & (cond==1000 | !taken).
  - Go to SLOT.
- State SLOT:
  - busy=1; annul_slot = annul_now & issue_valid & !stall (combinational).
  - On issue_valid&!stall, i.e. the slot has issued: go to REDIR if taken, else IDLE.
  - If the slot instruction is itself a Bicc: pulse dcti_err next cycle, ignore that branch, and continue with the first branch's outcome.
- State REDIR:
  - busy=1; redirect=1, registered, so asserted for exactly this one cycle; redirect_pc=target.
  - Any issue/br_valid this cycle is wrong-path and is ignored.
  - Next state IDLE regardless of stall.
- Latency:
  - Bicc issue at cycle t; earliest slot issue at t+1.
  - For a taken branch, redirect is high in the cycle after the slot issues, so earliest t+2.
- Stall:
  - IDLE/SLOT hold state; annul_slot=0.
  - Latched branch data is held.
- redirect_pc holds its last value when redirect=0.
- A mid-operation reset returns to IDLE immediately, with no redirect pulse, and clears icc.

Decomposition:
- Shared package (iu_pkg):
  - Cond encodings COND_BN…COND_BVC.
  - icc bit indices ICC_N=3, ICC_Z=2, ICC_V=1, ICC_C=0.
  - State enum IDLE/SLOT/REDIR.
- Sub-module iu_cond_eval: combinational, (cond[3:0], icc[3:0]) -> taken. It is reused later by Ticc.

Test Plan:
- Reset: hold rst_n=0 mid-SLOT -> icc=0, busy=0, redirect=0 asynchronously; no redirect after release.
- Bypass: icc_we=1, icc_in=4'b0100 (Z) in the same cycle as BE (cond 0001, a=0), br_pc=0x1000, br_disp=0x000010, then slot issue -> annul_slot=0; redirect=1 for one cycle; redirect_pc=0x1040.
- Annul untaken: icc=0, BE with a=1 -> annul_slot=1 during slot issue; no redirect; busy falls after slot.
- BA with a=1 and negative displacement: br_pc=0x0000_0008, br_disp=0x3FFFFE (−2) -> annul_slot=1, redirect_pc=0x0000_0000. Repeat with br_pc=0x4, disp −2 -> target 0xFFFF_FFFC (wrap).
- Stall in SLOT: 3 cycles of stall with issue_valid=1 -> annul_slot=0, state held; slot issues after stall drops; redirect on the following cycle.
- DCTI couple: BA, then BN issued in the slot -> dcti_err pulses once; redirect to the first BA target; the second branch has no effect.
- All 16 conds × 16 icc values exercised against a reference model of iu_cond_eval.
